// File: rtl/bombsquad_ram_pkg.sv
// ---------------------------------------------------------------------------
// bombsquad_ram_pkg
//   Shared definitions for the score/level RAM access arbiter:
//   - FSM state encoding (3-bit, legacy-compatible numeric values)
//   - RAM read/write control encoding
//   - default address/data widths used by the interface and the top
// ---------------------------------------------------------------------------
package bombsquad_ram_pkg;

  // Arbiter FSM states.
  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RDONE = 3'd4;

  // ram_r_w encoding.
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Default RAM geometry.
  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/ram_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_access_arbiter_if
//   Requester-side bus of the RAM access arbiter.
//   req        per-requester access request, held until gnt
//   req_we     per-requester direction (1 = write, 0 = read)
//   req_addr   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata  packed write data, same packing
//   gnt        one-hot, one-cycle pulse: access issued to the RAM
//   rd_valid   one-hot, one-cycle pulse: rd_data belongs to that requester
//   rd_data    shared read-result register
//   Modports: slave = arbiter side, master = requester side.
// ---------------------------------------------------------------------------
interface ram_access_arbiter_if
  import bombsquad_ram_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DATA_W  = DEFAULT_DATA_W
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output gnt, rd_valid, rd_data
  );

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  gnt, rd_valid, rd_data
  );

endinterface

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Searches req starting at last+1,
//   last+2, ... modulo NUM_REQ and returns the first set bit.
//   req     request vector
//   last    index of the previous winner
//   any     at least one request is set
//   winner  index of the chosen requester (0 when any = 0)
//   onehot  one-hot form of winner (all zero when any = 0)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               any,
  output logic [IDX_W-1:0]   winner,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search loop; a path that
    // leaves a combinational output unassigned infers a latch.
    any    = 1'b0;
    winner = '0;
    onehot = '0;
    idx    = 0;
    // k = NUM_REQ wraps back to last itself, so it has lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = IDX_W'(idx);
      end
    end
    if (any) onehot[winner] = 1'b1;
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// ---------------------------------------------------------------------------
// ram_access_arbiter
//   Sole master of the shared single-port score/level RAM. After reset it
//   zeroes addresses 0..CLEAR_DEPTH-1, then serves one read or write per
//   transaction, chosen round-robin among NUM_REQ requesters. Read results
//   are returned in rd_data with a per-requester rd_valid pulse.
//   Ports:
//     clk           system clock
//     reset         asynchronous, active-low reset
//     bus           requester bus (slave modport of ram_access_arbiter_if)
//     ram_addr      RAM address
//     ram_r_w       RAM control, 1 = write, 0 = read
//     ram_data_out  RAM write data
//     ram_data_in   RAM read data
//     busy          high in every state except IDLE
//   All outputs are registered.
// ---------------------------------------------------------------------------
module ram_access_arbiter
  import bombsquad_ram_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int CLEAR_DEPTH = 4,
  parameter int RD_LAT      = 1
) (
  input  logic                clk,
  input  logic                reset,
  ram_access_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_r_w,
  output logic [DATA_W-1:0]   ram_data_out,
  input  logic [DATA_W-1:0]   ram_data_in,
  output logic                busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Parameter sanity, caught at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("ram_access_arbiter: NUM_REQ must be 2..8");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("ram_access_arbiter: RD_LAT must be 1..4");
  end
  if (CLEAR_DEPTH < 0 || (ADDR_W < 31 && CLEAR_DEPTH > (1 << ADDR_W))) begin : g_bad_clear
    $error("ram_access_arbiter: CLEAR_DEPTH exceeds the address space");
  end

  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(CLEAR_DEPTH - 1);
  localparam logic [1:0]        WAIT_INIT = 2'(RD_LAT - 1);

  logic [2:0]         state;
  logic [ADDR_W-1:0]  clr_cnt;
  // clr_cnt is only ADDR_W wide, so a full-range clear would wrap it; the
  // separate done flag marks "last word written" independent of the count.
  logic               clr_done;
  logic [IDX_W-1:0]   rr_last;
  logic [1:0]         wait_cnt;

  // Transaction captured at the arbitration edge.
  logic [NUM_REQ-1:0] lat_onehot;
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (bus.req),
    .last   (rr_last),
    .any    (pick_any),
    .winner (pick_idx),
    .onehot (pick_onehot)
  );

  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_CLEAR;
      clr_cnt      <= '0;
      clr_done     <= (CLEAR_DEPTH == 0);
      rr_last      <= IDX_W'(NUM_REQ - 1);
      wait_cnt     <= '0;
      lat_onehot   <= '0;
      lat_we       <= RW_READ;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      bus.gnt      <= '0;
      bus.rd_valid <= '0;
      bus.rd_data  <= '0;
      ram_addr     <= '0;
      ram_r_w      <= RW_READ;
      ram_data_out <= '0;
      busy         <= 1'b1;
    end else begin
      // Grant and valid are single-cycle pulses.
      bus.gnt      <= '0;
      bus.rd_valid <= '0;

      unique case (state)
        S_CLEAR: begin
          if (clr_done) begin
            ram_r_w <= RW_READ;
            state   <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            ram_addr     <= clr_cnt;
            ram_data_out <= '0;
            ram_r_w      <= RW_WRITE;
            clr_cnt      <= clr_cnt + 1'b1;
            if (clr_cnt == CLR_LAST) clr_done <= 1'b1;
          end
        end

        S_IDLE: begin
          ram_r_w <= RW_READ;
          if (pick_any) begin
            lat_onehot <= pick_onehot;
            lat_we     <= bus.req_we[pick_idx];
            lat_addr   <= bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            lat_wdata  <= bus.req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
            rr_last    <= pick_idx;
            state      <= S_ISSUE;
            busy       <= 1'b1;
          end
        end

        S_ISSUE: begin
          ram_addr     <= lat_addr;
          ram_r_w      <= lat_we;
          ram_data_out <= lat_wdata;
          bus.gnt      <= lat_onehot;
          if (lat_we == RW_WRITE) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            wait_cnt <= WAIT_INIT;
            state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          ram_r_w <= RW_READ;
          if (wait_cnt == 2'd0) begin
            bus.rd_data <= ram_data_in;
            state       <= S_RDONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        S_RDONE: begin
          bus.rd_valid <= lat_onehot;
          state        <= S_IDLE;
          busy         <= 1'b0;
        end

        default: begin
          state <= S_CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_access_arbiter
//   Directed bench for ram_access_arbiter (NUM_REQ=3, 8-bit address/data,
//   CLEAR_DEPTH=4, RD_LAT=1). Stimulus pushes expected RAM clear writes,
//   grants and read completions (tagged with the expected cycle number) into
//   queues; a monitor on the falling edge pops and compares whenever the DUT
//   shows a grant, a clear write or a read-valid pulse.
//   Cycle k is the interval after the k-th rising edge since reset release.
// ---------------------------------------------------------------------------
module tb_ram_access_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] ram_addr;
  logic       ram_r_w;
  logic [7:0] ram_data_out;
  logic [7:0] ram_data_in;
  logic       busy;

  ram_access_arbiter_if #(.NUM_REQ(3), .ADDR_W(8), .DATA_W(8)) bus ();

  ram_access_arbiter #(
    .NUM_REQ     (3),
    .ADDR_W      (8),
    .DATA_W      (8),
    .CLEAR_DEPTH (4),
    .RD_LAT      (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .ram_addr     (ram_addr),
    .ram_r_w      (ram_r_w),
    .ram_data_out (ram_data_out),
    .ram_data_in  (ram_data_in),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: write on the rising edge, read data follows the address the
  // same cycle, so it is sampled one edge after the address was issued.
  logic [7:0] mem [256];
  always @(posedge clk) if (ram_r_w === 1'b1) mem[ram_addr] <= ram_data_out;
  assign ram_data_in = mem[ram_addr];

  int edge_n;
  always @(posedge clk or negedge reset) begin
    if (!reset) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] gq[$];
  logic [63:0] cq[$];
  logic [63:0] rq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pk_gnt(input int cyc, input logic [2:0] oh,
                                         input logic [7:0] a, input logic we,
                                         input logic [7:0] d);
    return {16'h0, 16'(cyc), 5'h0, oh, a, 7'h0, we, d};
  endfunction

  function automatic logic [63:0] pk_clr(input int cyc, input logic [7:0] a, input logic [7:0] d);
    return {32'h0, 16'(cyc), a, d};
  endfunction

  function automatic logic [63:0] pk_rd(input int cyc, input logic [2:0] oh, input logic [7:0] d);
    return {32'h0, 16'(cyc), 5'h0, oh, d};
  endfunction

  // Monitor.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bus.gnt !== 3'b000) begin
        if (gq.size() == 0)
          check("gnt_unexpected", {61'h0, bus.gnt}, 64'h0);
        else
          check("gnt", pk_gnt(edge_n, bus.gnt, ram_addr, ram_r_w, ram_data_out), gq.pop_front());
      end else if (ram_r_w !== 1'b0) begin
        if (cq.size() == 0)
          check("ram_write_unexpected", pk_clr(edge_n, ram_addr, ram_data_out), 64'h0);
        else
          check("clear_write", pk_clr(edge_n, ram_addr, ram_data_out), cq.pop_front());
      end
      if (bus.rd_valid !== 3'b000) begin
        if (rq.size() == 0)
          check("rd_valid_unexpected", {61'h0, bus.rd_valid}, 64'h0);
        else
          check("rd_valid", pk_rd(edge_n, bus.rd_valid, bus.rd_data), rq.pop_front());
      end
    end
  end

  // Wait for the falling edge inside cycle k (call before that edge).
  task automatic at_cycle(input int k);
    @(negedge clk);
    while (edge_n < k) @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic r, input logic we,
                         input logic [7:0] a, input logic [7:0] d);
    bus.req[i]             = r;
    bus.req_we[i]          = we;
    bus.req_addr[i*8 +: 8] = a;
    bus.req_wdata[i*8 +: 8] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #1 reset = 1'b0;
    #2;
    check("rst_gnt",          {61'h0, bus.gnt},      64'h0);
    check("rst_rd_valid",     {61'h0, bus.rd_valid}, 64'h0);
    check("rst_rd_data",      {56'h0, bus.rd_data},  64'h0);
    check("rst_ram_addr",     {56'h0, ram_addr},     64'h0);
    check("rst_ram_r_w",      {63'h0, ram_r_w},      64'h0);
    check("rst_ram_data_out", {56'h0, ram_data_out}, 64'h0);
    check("rst_busy",         {63'h0, busy},         64'h1);
    repeat (2) @(posedge clk);

    // Clear after reset release: writes of 0 to addresses 0..3 in cycles 1..4.
    for (int c = 1; c <= 4; c++) cq.push_back(pk_clr(c, 8'(c - 1), 8'h00));
    @(negedge clk);
    #2 reset = 1'b1;

    at_cycle(4);
    check("busy_clear_last", {63'h0, busy}, 64'h1);
    at_cycle(5);
    check("busy_after_clear", {63'h0, busy}, 64'h0);

    // Requester 1 writes 0x05 to 0x02; seen at edge 6, granted in cycle 7.
    set_req(1, 1'b1, 1'b1, 8'h02, 8'h05);
    gq.push_back(pk_gnt(7, 3'b010, 8'h02, 1'b1, 8'h05));
    at_cycle(6);
    check("busy_write_issue", {63'h0, busy}, 64'h1);
    at_cycle(7);
    check("busy_write_done", {63'h0, busy}, 64'h0);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Requester 2 reads 0x02: gnt in cycle 10, rd_valid with 0x05 in cycle 12.
    at_cycle(8);
    set_req(2, 1'b1, 1'b0, 8'h02, 8'h77);
    gq.push_back(pk_gnt(10, 3'b100, 8'h02, 1'b0, 8'h77));
    rq.push_back(pk_rd(12, 3'b100, 8'h05));
    at_cycle(10);
    set_req(2, 1'b0, 1'b0, 8'h00, 8'h00);

    // All three requesters write continuously: grants every other cycle,
    // strictly rotating 0,1,2,0,1,2 starting after the last winner (2).
    at_cycle(12);
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b1, 8'(8'h10 + i), 8'(8'hB0 + i));
    for (int t = 0; t < 6; t++)
      gq.push_back(pk_gnt(14 + 2 * t, 3'(1 << (t % 3)), 8'(8'h10 + t % 3), 1'b1, 8'(8'hB0 + t % 3)));
    at_cycle(24);
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 8'h00, 8'h00);

    // Read by requester 0, aborted by reset in its WAIT cycle.
    at_cycle(25);
    set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    gq.push_back(pk_gnt(27, 3'b001, 8'h10, 1'b0, 8'h00));
    at_cycle(26);
    check("rd_data_hold", {56'h0, bus.rd_data}, 64'h05);
    set_req(0, 1'b0, 1'b0, 8'h10, 8'h00);
    at_cycle(27);
    #2 reset = 1'b0;
    #1;
    check("abort_gnt",      {61'h0, bus.gnt},      64'h0);
    check("abort_rd_valid", {61'h0, bus.rd_valid}, 64'h0);
    check("abort_rd_data",  {56'h0, bus.rd_data},  64'h0);
    check("abort_busy",     {63'h0, busy},         64'h1);

    // Requests raised during reset/CLEAR wait for IDLE; requester 0 wins first.
    set_req(0, 1'b1, 1'b1, 8'h30, 8'h3C);
    set_req(1, 1'b1, 1'b1, 8'h31, 8'h3D);
    for (int c = 1; c <= 4; c++) cq.push_back(pk_clr(c, 8'(c - 1), 8'h00));
    gq.push_back(pk_gnt(7, 3'b001, 8'h30, 1'b1, 8'h3C));
    gq.push_back(pk_gnt(9, 3'b010, 8'h31, 1'b1, 8'h3D));
    @(negedge clk);
    #2 reset = 1'b1;
    at_cycle(7);
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    at_cycle(9);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);

    at_cycle(14);
    check("gnt_queue_drained",   64'(gq.size()), 64'h0);
    check("clear_queue_drained", 64'(cq.size()), 64'h0);
    check("rd_queue_drained",    64'(rq.size()), 64'h0);
    check("mem_0x12",            {56'h0, mem[8'h12]}, 64'hB2);
    check("mem_0x30",            {56'h0, mem[8'h30]}, 64'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Sole master of the shared single-port score/level RAM, sitting between the RAM and its requesters (e.g. level/score controller, display readout, debug port).
- After reset, clears the first CLEAR_DEPTH words.
- Then serves one read or write per transaction, chosen round-robin among NUM_REQ requesters, and returns read data with a per-requester valid pulse.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- CLEAR_DEPTH, 4, words zeroed after reset (addresses 0..CLEAR_DEPTH-1); 0 = skip clear.
- RD_LAT, 1, RAM read latency in cycles from address-valid edge (1..4).

Ports:
- clk  in  1  system clock (50 MHz on-board); single clock domain.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester access request; hold until gnt.
- req_we  in  NUM_REQ  per-requester: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: access issued to RAM this cycle.
- rd_valid  out  NUM_REQ  one-hot, one-cycle pulse: rd_data holds this requester's read result.
- rd_data  out  DATA_W  shared read-result register.
- ram_addr  out  ADDR_W  RAM address.
- ram_r_w  out  1  RAM control: 1 = write, 0 = read.
- ram_data_out  out  DATA_W  RAM write data.
- ram_data_in  in  DATA_W  RAM read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (asynchronous, while reset = 0):
  - state = CLEAR, clr_cnt = 0, rr_last = NUM_REQ-1 (so requester 0 wins first).
  - gnt = 0, rd_valid = 0, rd_data = 0, ram_addr = 0, ram_r_w = 0, ram_data_out = 0, busy = 1.
- All outputs are registered.
- States: CLEAR, IDLE, ISSUE, WAIT, RDONE.
- CLEAR:
  - Each cycle: ram_addr = clr_cnt, ram_data_out = 0, ram_r_w = 1; clr_cnt increments.
  - After the write to CLEAR_DEPTH-1, go to IDLE with ram_r_w = 0. Clear takes exactly CLEAR_DEPTH cycles.
  - CLEAR_DEPTH = 0: go to IDLE on the first edge with no write.
  - req is ignored during CLEAR; no gnt is issued.
- IDLE:
  - ram_r_w = 0; ram_addr holds its last value.
  - If any req is set, pick winner w = first set bit searching rr_last+1, rr_last+2, ... modulo NUM_REQ.
  - Latch w, req_we[w], req_addr[w] and req_wdata[w] at that edge; set rr_last = w; go to ISSUE.
  - Requester changes after the latching edge are ignored.
- ISSUE (1 cycle):
  - ram_addr = latched addr, ram_r_w = latched we, ram_data_out = latched wdata; gnt[w] = 1.
  - Write: next state IDLE, ram_r_w returns to 0.
  - Read: next state WAIT.
- WAIT (RD_LAT cycles):
  - ram_r_w = 0, address held.
  - On the last WAIT edge, rd_data <= ram_data_in; go to RDONE.
- RDONE (1 cycle): rd_valid[w] = 1, rd_data stable; next state IDLE.
- rd_data holds its value until the next read completes.
- Latency, with req seen at edge 0:
  - Write: gnt and RAM write in cycle 1; next arbitration at edge 2.
  - Read: gnt in cycle 1; rd_valid in cycle 2+RD_LAT; next arbitration at edge 3+RD_LAT.
- A requester dropping req after being latched does not cancel its access; gnt and rd_valid still fire.
- A requester keeping req high after gnt is treated as a new request and competes round-robin again.
- Fairness: with all requesters continuously active, grants cycle 0,1,...,NUM_REQ-1,0,...
- Address arithmetic:
  - clr_cnt is ADDR_W wide.
  - CLEAR_DEPTH > 2^ADDR_W is a parameter error; flag with an elaboration-time check.
- Reset asserted mid-transaction: immediate abort.
  - gnt and rd_valid drop; any pending read result is discarded.
  - After release, CLEAR reruns from address 0.

Decomposition:
- Package bombsquad_ram_pkg holds:
  - state encoding (CLEAR=0, IDLE=1, ISSUE=2, WAIT=3, RDONE=4, 3-bit);
  - constants RW_READ = 0, RW_WRITE = 1;
  - default widths ADDR_W = 8, DATA_W = 8.
- Sub-module rr_pick (combinational): inputs req[NUM_REQ] and last[index]; outputs any, winner index, one-hot. Round-robin logic is tested standalone.

Test Plan:
- Reset release, CLEAR_DEPTH=4, req=0 -> ram_r_w=1 with addr 0,1,2,3 and data 0 in cycles 1-4; busy falls in cycle 5; no gnt.
- After clear, req[1]=1, we=1, addr=0x02, wdata=0x05 -> gnt=3'b010 one cycle later with ram_addr=0x02, ram_r_w=1, ram_data_out=0x05; busy low two cycles after request.
- req[2] read addr 0x02 with RAM model returning 0x05 at RD_LAT=1 -> gnt[2] in cycle 1, rd_valid=3'b100 and rd_data=0x05 in cycle 3, rd_valid[0..1]=0.
- req=3'b111 held for 6 transactions, all writes -> gnt order 001,010,100,001,010,100; no requester starved.
- Assert req[0] during CLEAR -> no gnt until IDLE; first grant goes to requester 0 once CLEAR finishes.
- Pull reset low during WAIT of a read -> gnt=0, rd_valid=0, rd_data=0 immediately; after release CLEAR restarts at address 0 and the aborted read never reports valid.
